mem_bus: RTL

//  Memory-side stage directly downstream of the cpu memory port (ren/addr/wdata/wmask/wen in, rdata/rd_valid out).

---
 rtl/mem_bus.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mem_bus.sv
// Memory-side bus stage: decodes cpu accesses to an external synchronous RAM and a
// memory-mapped 8N1 UART transmitter with a small TX FIFO; reads return after 1 cycle.
module mem_bus #(
  parameter int unsigned RAM_AW     = 13,
  parameter int unsigned CLK_DIV    = 104,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ren,
  input  logic [15:0]       addr,
  input  logic              wen,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wmask,
  output logic [31:0]       rdata,
  output logic              rd_valid,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              uart_tx
);

  localparam logic [15:0] UartDataAddr = 16'h8000;
  localparam logic [15:0] UartStatAddr = 16'h8004;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned DivW = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] FifoFull = CntW'(FIFO_DEPTH);
  localparam logic [DivW-1:0] DivLast  = DivW'(CLK_DIV - 1);

  typedef enum logic [1:0] {SelZero, SelRam, SelStat} rd_sel_e;
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_e;

  // RAM path is pure pass-through; byte lanes are mirrored between wmask and ram_we
  assign ram_en    = (ren | wen) & ~addr[15];
  assign ram_we    = wen ? {wmask[0], wmask[1], wmask[2], wmask[3]} : 4'b0000;
  assign ram_addr  = addr[RAM_AW+1:2];
  assign ram_wdata = wdata;

  rd_sel_e   rd_sel_d, rd_sel_q;
  logic      rd_valid_d, rd_valid_q;

  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0] wptr_d, wptr_q, rptr_d, rptr_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            ovf_d, ovf_q;
  logic            fifo_full, fifo_empty, fifo_pop, push_req, push_ok;

  tx_state_e       state_d, state_q;
  logic [DivW-1:0] div_d, div_q;
  logic [2:0]      bit_d, bit_q;
  logic [7:0]      shift_d, shift_q;
  logic            tx_busy;

  // Read decode: target captured with the request, data muxed in the return cycle
  always_comb begin
    rd_valid_d = ren & ~wen;
    rd_sel_d   = SelZero;
    if (!addr[15]) begin
      rd_sel_d = SelRam;
    end else if (addr == UartStatAddr) begin
      rd_sel_d = SelStat;
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_valid_q) begin
      unique case (rd_sel_q)
        SelRam:  rdata = ram_rdata;
        SelStat: rdata = {28'b0, ovf_q, fifo_empty, tx_busy, fifo_full};
        default: rdata = '0;
      endcase
    end
  end

  assign rd_valid = rd_valid_q;

  assign fifo_full  = (cnt_q == FifoFull);
  assign fifo_empty = (cnt_q == '0);
  assign push_req   = wen & (addr == UartDataAddr) & wmask[3];
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands
  assign push_ok    = push_req & (~fifo_full | fifo_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (push_ok) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (fifo_pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    if (push_ok && !fifo_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!push_ok && fifo_pop) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (rd_valid_q && (rd_sel_q == SelStat)) begin
      ovf_d = 1'b0;
    end
    if (push_req && !push_ok) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wptr_q] <= wdata[7:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    uart_tx  = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_mem[rptr_q];
          div_d    = DivLast;
          state_d  = StStart;
        end
      end
      StStart: begin
        uart_tx = 1'b0;
        if (div_q == '0) begin
          div_d   = DivLast;
          bit_d   = 3'd0;
          state_d = StData;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      StData: begin
        uart_tx = shift_q[0];
        if (div_q == '0) begin
          div_d   = DivLast;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      StStop: begin
        if (div_q == '0) begin
          state_d = StIdle;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign tx_busy = (state_q != StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_sel_q   <= SelZero;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      state_q    <= StIdle;
      div_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_sel_q   <= rd_sel_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
    end
  end

endmodule
